conv_psum_collector: RTL and testbench

Consumes the row partial sums leaving the convolutional PE mesh and writes finished output neurons back toward the neuron buffer. It accumulates D parallel lanes over a programmed number of passes (input channels / kernel slices) and saturates each lane to W bits. A drain register lets accumulation of the next tile overlap with the draining of the current one. It then serialises the D results one word per cycle onto a valid/ready write port with addresses.

---
 rtl/conv_psum_collector.sv | 192 +++++++++++++++++++
 tb/tb_conv_psum_collector.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_collector.sv
// Accumulates D mesh partial-sum lanes over a programmed pass count, saturates, and drains
// each finished tile one word per cycle. Define CONV_COLLECT_RELU_EN to clamp negative sums to 0.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | accumulating passes, handing finished tiles to the drain register
// S_FLUSH | all tiles handed off, waiting for the drain register to empty
module conv_psum_collector #(
  parameter int DEPTH = 2,
  parameter int D     = 1 << DEPTH,
  parameter int W     = 16,
  parameter int A     = 7
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [7:0]     i_pass_count,
  input  logic [7:0]     i_tile_count,
  input  logic [A-1:0]   i_base_addr,
  input  logic [W*D-1:0] i_psum,
  input  logic           i_psum_valid,
  output logic [W-1:0]   o_out_data,
  output logic [A-1:0]   o_out_addr,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic           o_stall,
  output logic           o_overflow,
  output logic           o_busy,
  output logic           o_done
);

  localparam int AW = W + 8;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]           r_pass_total;
  logic [7:0]           r_pass;
  logic [7:0]           r_tile_total;
  logic [7:0]           r_tile;
  logic [A-1:0]         r_tile_base;
  logic [A-1:0]         r_drain_base;
  logic signed [AW-1:0] r_acc [D];
  logic signed [W-1:0]  r_drain [D];
  logic                 r_drain_full;
  logic                 r_pending;
  logic                 r_overflow;
  logic [DEPTH-1:0]     r_lane;

  logic signed [AW-1:0] w_sum [D];
  logic signed [W-1:0]  w_res_new [D];
  logic signed [W-1:0]  w_res_pend [D];
  logic                 w_fire;
  logic                 w_last;
  logic                 w_drain_free;
  logic                 w_accept;
  logic                 w_final;
  logic                 w_xfer_new;
  logic                 w_xfer_pend;
  logic                 w_xfer;
  logic                 w_tiles_done;
  logic                 w_launch;

  function automatic logic signed [W-1:0] f_clip(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] x;
    x = v;
`ifdef CONV_COLLECT_RELU_EN
    if (x < 0) x = '0;
`endif
    if (x > SAT_MAX) x = SAT_MAX;
    else if (x < SAT_MIN) x = SAT_MIN;
    return x[W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < D; i++) begin
      w_sum[i]      = r_acc[i] + {{(AW-W){i_psum[W*(i+1)-1]}}, i_psum[W*i +: W]};
      w_res_new[i]  = f_clip(w_sum[i]);
      w_res_pend[i] = f_clip(r_acc[i]);
    end
  end

  // A final pass may hand off on the same edge the drain releases its last word.
  assign w_fire       = r_drain_full && i_out_ready;
  assign w_last       = w_fire && (r_lane == DEPTH'(D-1));
  assign w_drain_free = !r_drain_full || w_last;
  assign w_accept     = (r_state == S_RUN) && i_psum_valid && !r_pending;
  assign w_final      = w_accept && (r_pass == r_pass_total - 8'd1);
  assign w_xfer_new   = w_final && w_drain_free;
  assign w_xfer_pend  = r_pending && w_last;
  assign w_xfer       = w_xfer_new || w_xfer_pend;
  assign w_tiles_done = w_xfer && ((r_tile + 8'd1) == r_tile_total);
  assign w_launch     = (r_state == S_IDLE) && i_start;

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = (i_tile_count == 8'd0) ? S_FLUSH : S_RUN;
      end
      S_RUN: begin
        if (w_tiles_done) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (!r_drain_full && !r_pending) begin
          o_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass_total <= 8'd1;
      r_pass       <= '0;
      r_tile_total <= '0;
      r_tile       <= '0;
      r_tile_base  <= '0;
      r_drain_base <= '0;
      r_drain_full <= 1'b0;
      r_pending    <= 1'b0;
      r_overflow   <= 1'b0;
      r_lane       <= '0;
      for (int i = 0; i < D; i++) begin
        r_acc[i]   <= '0;
        r_drain[i] <= '0;
      end
    end else begin
      if (w_launch) begin
        r_pass_total <= (i_pass_count == 8'd0) ? 8'd1 : i_pass_count;
        r_tile_total <= i_tile_count;
        r_tile_base  <= i_base_addr;
        r_pass       <= '0;
        r_tile       <= '0;
        r_overflow   <= 1'b0;
        r_pending    <= 1'b0;
        for (int i = 0; i < D; i++) r_acc[i] <= '0;
      end

      if (w_accept) begin
        if (w_xfer_new) begin
          r_pass <= '0;
          for (int i = 0; i < D; i++) r_acc[i] <= '0;
        end else begin
          r_pass <= r_pass + 8'd1;
          for (int i = 0; i < D; i++) r_acc[i] <= w_sum[i];
          if (w_final) r_pending <= 1'b1;
        end
      end

      if ((r_state == S_RUN) && i_psum_valid && r_pending) r_overflow <= 1'b1;

      if (w_xfer_pend) begin
        r_pending <= 1'b0;
        r_pass    <= '0;
        for (int i = 0; i < D; i++) r_acc[i] <= '0;
      end

      if (w_fire) r_lane       <= r_lane + DEPTH'(1);
      if (w_last) r_drain_full <= 1'b0;

      if (w_xfer) begin
        r_drain_full <= 1'b1;
        r_lane       <= '0;
        r_drain_base <= r_tile_base;
        r_tile_base  <= r_tile_base + A'(D);
        r_tile       <= r_tile + 8'd1;
        for (int i = 0; i < D; i++) r_drain[i] <= w_xfer_new ? w_res_new[i] : w_res_pend[i];
      end
    end
  end

  assign o_out_valid = r_drain_full;
  assign o_out_data  = r_drain[r_lane];
  assign o_out_addr  = r_drain_base + A'(r_lane);
  assign o_stall     = r_pending;
  assign o_overflow  = r_overflow;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_psum_collector.sv
// Directed bench for conv_psum_collector: expected writes come from a per-tile arithmetic
// model (sum, optional ReLU, saturate, base + lane) plus hand-computed literal words.
module tb_conv_psum_collector;
  localparam int DEPTH = 2;
  localparam int D     = 4;
  localparam int W     = 16;
  localparam int A     = 7;
`ifdef CONV_COLLECT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef int lanes_t [D];

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     pass_count = '0;
  logic [7:0]     tile_count = '0;
  logic [A-1:0]   base_addr = '0;
  logic [W*D-1:0] psum = '0;
  logic           psum_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [A-1:0]   out_addr;
  logic           out_valid;
  logic           stall;
  logic           overflow;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_errors = 0;
  int exp_addr[$];
  int exp_data[$];

  always #5 clk = ~clk;

  conv_psum_collector #(.DEPTH(DEPTH), .D(D), .W(W), .A(A)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_pass_count (pass_count),
    .i_tile_count (tile_count),
    .i_base_addr  (base_addr),
    .i_psum       (psum),
    .i_psum_valid (psum_valid),
    .o_out_data   (out_data),
    .o_out_addr   (out_addr),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_stall      (stall),
    .o_overflow   (overflow),
    .o_busy       (busy),
    .o_done       (done)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference arithmetic for one finished lane sum.
  function automatic int model_word(input int sum);
    int v;
    v = sum;
    if (RELU && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic push_lit(input int addr, input int data);
    exp_addr.push_back(addr);
    exp_data.push_back(data);
  endtask

  task automatic push_tile(input int base, input lanes_t sums);
    for (int i = 0; i < D; i++) begin
      exp_addr.push_back((base + i) % (1 << A));
      exp_data.push_back(model_word(sums[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_psum(input lanes_t v);
    for (int i = 0; i < D; i++) psum[W*i +: W] = W'(v[i]);
  endtask

  task automatic send_pass(input lanes_t v);
    set_psum(v);
    psum_valid = 1'b1;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] pc, input logic [7:0] tc, input logic [A-1:0] base);
    pass_count = pc;
    tile_count = tc;
    base_addr  = base;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles, output int cyc);
    cyc = 0;
    while (!done && cyc < max_cycles) begin
      tick();
      cyc++;
    end
    check({name, "_done_seen"}, done, 1);
  endtask

  // Output checker: every handshake is matched in order against the expected write queue,
  // and a stalled word must not change.
  logic           prev_hold = 1'b0;
  logic [W-1:0]   prev_data = '0;
  logic [A-1:0]   prev_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_addr", out_addr, prev_addr);
      end
      if (out_valid && out_ready) begin
        check("write_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) begin
          check("wr_addr", out_addr, exp_addr.pop_front());
          check("wr_data", $signed(out_data), exp_data.pop_front());
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_addr = out_addr;
    end
  end

  task automatic run_basic(input string tag);
    lanes_t v;
    int cyc;
    v = '{1, 2, 3, 4};
    out_ready = 1'b1;
    do_start(8'd1, 8'd1, 7'd10);
    check({tag, "_busy_after_start"}, busy, 1);
    push_lit(10, 1);
    push_lit(11, 2);
    push_lit(12, 3);
    push_lit(13, 4);
    send_pass(v);
    check({tag, "_latency_valid"}, out_valid, 1);
    check({tag, "_first_addr"}, out_addr, 10);
    wait_done(tag, 20, cyc);
    check({tag, "_done_cycles"}, cyc, D);
    check({tag, "_queue_empty"}, exp_addr.size(), 0);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_clear"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t ta, tb, tx, tc;
    int cyc;

    #12;
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_basic("basic");

    // Three passes, back to back
    do_start(8'd3, 8'd1, 7'd20);
    push_lit(20, 75);
    push_lit(21, RELU ? 0 : -30);
    push_lit(22, 0);
    push_lit(23, 24);
    psum_valid = 1'b1;
    ta = '{100, -10, 0, 7};  set_psum(ta); tick();
    ta = '{-50, -10, 0, 8};  set_psum(ta); tick();
    ta = '{25, -10, 0, 9};   set_psum(ta); tick();
    psum_valid = 1'b0;
    check("acc3_latency_valid", out_valid, 1);
    wait_done("acc3", 20, cyc);
    check("acc3_queue_empty", exp_addr.size(), 0);
    tick();

    // Saturation at both rails
    do_start(8'd2, 8'd1, 7'd40);
    push_lit(40, 32767);
    push_lit(41, RELU ? 0 : -32768);
    push_lit(42, RELU ? 0 : -2);
    push_lit(43, 32767);
    psum_valid = 1'b1;
    ta = '{30000, -30000, -5, 32767}; set_psum(ta); tick();
    ta = '{30000, -30000, 3, 1};      set_psum(ta); tick();
    psum_valid = 1'b0;
    wait_done("sat", 20, cyc);
    check("sat_queue_empty", exp_addr.size(), 0);
    tick();

    // Back-pressure: drain occupied, pending tile, dropped pass
    out_ready = 1'b0;
    ta = '{1000, -2000, 3, -4};
    tb = '{-7, 8, -32768, 32767};
    tx = '{9, 9, 9, 9};
    tc = '{5, -6, 7, -8};
    do_start(8'd1, 8'd3, 7'd50);
    push_tile(50, ta);
    push_tile(54, tb);
    push_tile(58, tc);
    send_pass(ta);
    check("bp_tile0_valid", out_valid, 1);
    check("bp_tile0_nostall", stall, 0);
    send_pass(tb);
    check("bp_stall_set", stall, 1);
    check("bp_overflow_clear", overflow, 0);
    send_pass(tx);
    check("bp_overflow_set", overflow, 1);
    tick();
    tick();
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("bp_stall_held", stall, 1);
    tick();
    check("bp_stall_released", stall, 0);
    check("bp_tile1_addr", out_addr, 54);
    tick(); tick(); tick(); tick();
    check("bp_waiting_busy", busy, 1);
    check("bp_waiting_nodone", done, 0);
    check("bp_waiting_novalid", out_valid, 0);
    send_pass(tc);
    wait_done("bp", 20, cyc);
    check("bp_overflow_sticky", overflow, 1);
    check("bp_queue_empty", exp_addr.size(), 0);
    tick();

    // Address wrap, passCount 0 acts as 1
    ta = '{-1, 5, -32768, 100};
    do_start(8'd0, 8'd1, 7'd126);
    check("wrap_overflow_cleared", overflow, 0);
    push_tile(126, ta);
    send_pass(ta);
    check("wrap_addr_lane0", out_addr, 126);
    tick(); tick();
    check("wrap_addr_lane2", out_addr, 0);
    wait_done("wrap", 20, cyc);
    check("wrap_done_cycles", cyc, D - 2);
    check("wrap_queue_empty", exp_addr.size(), 0);
    tick();

    // Final pass lands on the edge the drain releases its last word
    ta = '{11, 12, 13, 14};
    tb = '{21, 22, 23, 24};
    do_start(8'd1, 8'd2, 7'd0);
    push_tile(0, ta);
    push_tile(4, tb);
    send_pass(ta);
    tick(); tick(); tick();
    send_pass(tb);
    check("edge_nostall", stall, 0);
    check("edge_valid", out_valid, 1);
    check("edge_addr", out_addr, 4);
    wait_done("edge", 20, cyc);
    check("edge_done_cycles", cyc, D);
    check("edge_queue_empty", exp_addr.size(), 0);
    tick();

    // Empty run
    do_start(8'd1, 8'd0, 7'd5);
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    tick();
    check("zero_done_pulse", done, 0);
    check("zero_busy_clear", busy, 0);

    // Asynchronous reset mid-drain
    ta = '{1, 2, 3, 4};
    do_start(8'd1, 8'd1, 7'd10);
    push_lit(10, 1);
    push_lit(11, 2);
    push_lit(12, 3);
    push_lit(13, 4);
    send_pass(ta);
    tick(); tick();
    check("prerst_lane2_addr", out_addr, 12);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_stall", stall, 0);
    exp_addr.delete();
    exp_data.delete();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_basic("after_rst");

    check("final_queue_empty", exp_addr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
